// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus bundle for the SIC-4 fetch controller: the instruction
// memory read port, the valid/ready instruction channel toward decode, and
// the redirect request coming back from execute.
interface instr_fetch_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;

    // Fetch controller side.
    modport master (
        output imem_addr,
        input  imem_data,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  redirect_valid,
        input  redirect_addr
    );

    // Memory / decode / execute side.
    modport slave (
        input  imem_addr,
        output imem_data,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output redirect_valid,
        output redirect_addr
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// SIC-4 instruction fetch controller. Owns the PC, addresses the
// combinational instruction memory and holds one fetched instruction in a
// registered output stage handed to decode over valid/ready. Redirects
// flush the stage and reload the PC; the HALT opcode stops fetching until
// start is seen again.
module instr_fetch_ctrl #(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = 8'h00,
    parameter logic [DATA_W-1:0] HALT_OPCODE = 8'hFF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                halted,
    instr_fetch_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FETCH     = 2'd1,
        ST_HALT_PEND = 2'd2,
        ST_HALTED    = 2'd3
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] next_pc_s;
    logic [DATA_W-1:0] instr_r;
    logic [DATA_W-1:0] next_instr_s;
    logic [ADDR_W-1:0] instr_pc_r;
    logic [ADDR_W-1:0] next_instr_pc_s;
    logic              instr_valid_r;
    logic              next_instr_valid_s;
    logic              halted_r;
    logic              next_halted_s;
    logic              slot_free_s;
    logic              transfer_s;

    // Handshake qualifiers: the stage can take a new byte when empty or when
    // its current content leaves this edge.
    always_comb begin
        slot_free_s = !instr_valid_r || bus.instr_ready;
        transfer_s  = instr_valid_r && bus.instr_ready;
    end

    // Next-state and datapath update; redirect outranks capture and transfer.
    always_comb begin
        next_state_s       = state_r;
        next_pc_s          = pc_r;
        next_instr_s       = instr_r;
        next_instr_pc_s    = instr_pc_r;
        next_instr_valid_s = instr_valid_r;
        next_halted_s      = halted_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (bus.redirect_valid) begin
                    next_instr_valid_s = 1'b0;
                    next_pc_s          = bus.redirect_addr;
                    next_state_s       = ST_FETCH;
                end else if (slot_free_s) begin
                    next_instr_s       = bus.imem_data;
                    next_instr_pc_s    = pc_r;
                    next_instr_valid_s = 1'b1;
                    next_pc_s          = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (bus.imem_data == HALT_OPCODE) begin
                        next_state_s = ST_HALT_PEND;
                    end else begin
                        next_state_s = ST_FETCH;
                    end
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_HALT_PEND: begin
                if (bus.redirect_valid) begin
                    next_instr_valid_s = 1'b0;
                    next_pc_s          = bus.redirect_addr;
                    next_state_s       = ST_FETCH;
                end else if (transfer_s) begin
                    next_instr_valid_s = 1'b0;
                    next_halted_s      = 1'b1;
                    next_state_s       = ST_HALTED;
                end else begin
                    next_state_s = ST_HALT_PEND;
                end
            end
            ST_HALTED: begin
                if (start) begin
                    next_pc_s     = RESET_PC;
                    next_halted_s = 1'b0;
                    next_state_s  = ST_FETCH;
                end else begin
                    next_state_s = ST_HALTED;
                end
            end
            default: begin
                next_state_s       = ST_IDLE;
                next_pc_s          = RESET_PC;
                next_instr_valid_s = 1'b0;
                next_halted_s      = 1'b0;
            end
        endcase
    end

    // State, PC and output stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            instr_r       <= {DATA_W{1'b0}};
            instr_pc_r    <= {ADDR_W{1'b0}};
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            pc_r          <= next_pc_s;
            instr_r       <= next_instr_s;
            instr_pc_r    <= next_instr_pc_s;
            instr_valid_r <= next_instr_valid_s;
            halted_r      <= next_halted_s;
        end
    end

    // The memory is addressed straight from the PC so its data is ready for
    // the same edge that captures it.
    assign bus.imem_addr   = pc_r;
    assign bus.instr       = instr_r;
    assign bus.instr_pc    = instr_pc_r;
    assign bus.instr_valid = instr_valid_r;
    assign halted          = halted_r;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: reset, streaming, backpressure,
// redirect, PC wrap and halt/restart, with hand-computed expectations.
module tb_instr_fetch_ctrl;

    logic clk;
    logic rst_n;
    logic start;
    logic halted;
    logic [7:0] mem [256];
    int n_checks;
    int n_errors;

    instr_fetch_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    instr_fetch_ctrl #(
        .ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00), .HALT_OPCODE(8'hFF)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .halted (halted),
        .bus    (bus.master)
    );

    assign bus.imem_data = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] ins, input logic [7:0] pc,
                             input logic [7:0] addr);
        check({tag, "_valid"}, 8'(bus.instr_valid), 8'h01);
        check({tag, "_instr"}, bus.instr, ins);
        check({tag, "_pc"}, bus.instr_pc, pc);
        check({tag, "_addr"}, bus.imem_addr, addr);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int a = 0; a < 256; a++) mem[a] = 8'(a + 16);
        rst_n = 1'b0;
        start = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 8'h00;
        tick(3);
        check("rst_valid", 8'(bus.instr_valid), 8'h00);
        check("rst_addr", bus.imem_addr, 8'h00);
        check("rst_halted", 8'(halted), 8'h00);
        check("rst_instr", bus.instr, 8'h00);
        check("rst_pc", bus.instr_pc, 8'h00);
        rst_n = 1'b1;

        // Idle without start: nothing happens.
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("idle_valid", 8'(bus.instr_valid), 8'h00);
        end
        check("idle_addr", bus.imem_addr, 8'h00);

        // Stream with ready held high.
        start = 1'b1;
        bus.instr_ready = 1'b1;
        tick(1);
        start = 1'b0;
        check("str_novalid", 8'(bus.instr_valid), 8'h00);
        tick(1);
        check_out("str0", 8'h10, 8'h00, 8'h01);
        tick(1);
        check_out("str1", 8'h11, 8'h01, 8'h02);
        tick(1);
        check_out("str2", 8'h12, 8'h02, 8'h03);

        // Backpressure: stage and PC hold.
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_out("bp_hold", 8'h12, 8'h02, 8'h03);
        end
        bus.instr_ready = 1'b1;
        tick(1);
        check_out("bp_rel", 8'h13, 8'h03, 8'h04);

        // Redirect while holding a valid instruction with ready low.
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 8'h40;
        tick(1);
        bus.redirect_valid = 1'b0;
        check("rd_valid", 8'(bus.instr_valid), 8'h00);
        check("rd_addr", bus.imem_addr, 8'h40);
        tick(1);
        check_out("rd_fetch", 8'h50, 8'h40, 8'h41);

        // Redirect to the top of the address space, then wrap.
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 8'hFF;
        tick(1);
        bus.redirect_valid = 1'b0;
        check("wr_drop", 8'(bus.instr_valid), 8'h00);
        check("wr_addr", bus.imem_addr, 8'hFF);
        tick(1);
        check_out("wr_ff", 8'h0F, 8'hFF, 8'h00);
        tick(1);
        check_out("wr_00", 8'h10, 8'h00, 8'h01);

        // Asynchronous reset in the middle of streaming.
        rst_n = 1'b0;
        #1;
        check("arst_valid", 8'(bus.instr_valid), 8'h00);
        check("arst_addr", bus.imem_addr, 8'h00);
        check("arst_halted", 8'(halted), 8'h00);
        tick(1);
        rst_n = 1'b1;

        // Halt: HALT opcode at 0x05.
        mem[5] = 8'hFF;
        start = 1'b1;
        bus.instr_ready = 1'b1;
        tick(1);
        start = 1'b0;
        tick(6);
        check_out("h_cap", 8'hFF, 8'h05, 8'h06);
        bus.instr_ready = 1'b0;
        start = 1'b1;
        tick(2);
        start = 1'b0;
        check_out("h_pend", 8'hFF, 8'h05, 8'h06);
        check("h_pend_halted", 8'(halted), 8'h00);
        bus.instr_ready = 1'b1;
        tick(1);
        check("h_valid", 8'(bus.instr_valid), 8'h00);
        check("h_halted", 8'(halted), 8'h01);
        check("h_addr", bus.imem_addr, 8'h06);
        tick(2);
        check("h_stay_halted", 8'(halted), 8'h01);
        check("h_stay_addr", bus.imem_addr, 8'h06);
        check("h_stay_valid", 8'(bus.instr_valid), 8'h00);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 8'h40;
        tick(1);
        bus.redirect_valid = 1'b0;
        check("h_rd_ignored", bus.imem_addr, 8'h06);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("rs_halted", 8'(halted), 8'h00);
        check("rs_addr", bus.imem_addr, 8'h00);
        check("rs_valid", 8'(bus.instr_valid), 8'h00);
        tick(1);
        check_out("rs_fetch", 8'h10, 8'h00, 8'h01);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
